// File: rtl/netwalk_exec_pkg.sv
// Shared width defaults and derivation helpers for the NetWalk execution engine.
package netwalk_exec_pkg;

  localparam int DEFAULT_ACTION_FLAG_WIDTH = 16;
  localparam int DEFAULT_ACTION_SET_WIDTH  = 356;
  localparam int DEFAULT_TCAM_ADDR_WIDTH   = 6;
  localparam int DEFAULT_PKT_HEADER_WIDTH  = 512;

  // A program word is {flag, set}: flag in the MSBs, set in the LSBs.
  function automatic int program_data_width(input int flag_width, input int set_width);
    return flag_width + set_width;
  endfunction

  function automatic int table_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/netwalk_action_mem.sv
// Action table storage: one write port, one synchronous read port, read-before-write.
module netwalk_action_mem
  import netwalk_exec_pkg::*;
#(
  parameter int DATA_WIDTH = program_data_width(DEFAULT_ACTION_FLAG_WIDTH, DEFAULT_ACTION_SET_WIDTH),
  parameter int ADDR_WIDTH = DEFAULT_TCAM_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = table_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset; the valid bits in the parent qualify every
  // entry, so stale contents are never visible and the array maps to RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/netwalk_execution_engine_action_fetch_unit.sv
// Action fetch: one-cycle lookup of the action table with per-entry valid bits.
// Define NETWALK_AF_WRITE_FORWARD_EN to forward same-cycle program/delete to a lookup.
module netwalk_execution_engine_action_fetch_unit
  import netwalk_exec_pkg::*;
#(
  parameter  int ACTION_FLAG_WIDTH  = DEFAULT_ACTION_FLAG_WIDTH,
  parameter  int ACTION_SET_WIDTH   = DEFAULT_ACTION_SET_WIDTH,
  parameter  int TCAM_ADDR_WIDTH    = DEFAULT_TCAM_ADDR_WIDTH,
  parameter  int PKT_HEADER_WIDTH   = DEFAULT_PKT_HEADER_WIDTH,
  localparam int PROGRAM_DATA_WIDTH = program_data_width(ACTION_FLAG_WIDTH, ACTION_SET_WIDTH)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [PROGRAM_DATA_WIDTH-1:0] exec_program_data,
  input  logic [TCAM_ADDR_WIDTH-1:0]    exec_program_addr,
  input  logic                          exec_program_enable,
  input  logic                          exec_delete_enable,
  input  logic [PKT_HEADER_WIDTH-1:0]   pkt_header_in,
  input  logic [TCAM_ADDR_WIDTH-1:0]    exec_of_match_addr,
  input  logic                          exec_of_match_found,
  output logic [ACTION_FLAG_WIDTH-1:0]  exec_action_flag,
  output logic [ACTION_SET_WIDTH-1:0]   exec_action_set,
  output logic                          exec_action_enable,
  output logic [PKT_HEADER_WIDTH-1:0]   pkt_header_out
);

  localparam int DEPTH = table_depth(TCAM_ADDR_WIDTH);

  logic [DEPTH-1:0]              valid;
  logic                          wr_en;
  logic                          lookup_hit;
  logic                          enable_q;
  logic [PKT_HEADER_WIDTH-1:0]   header_q;
  logic [PROGRAM_DATA_WIDTH-1:0] rd_data;
  logic [PROGRAM_DATA_WIDTH-1:0] fetched;

  // Delete wins over program, and nothing is written while in reset.
  assign wr_en = exec_program_enable & ~exec_delete_enable & ~reset;

  netwalk_action_mem #(
    .DATA_WIDTH (PROGRAM_DATA_WIDTH),
    .ADDR_WIDTH (TCAM_ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (exec_program_addr),
    .wr_data (exec_program_data),
    .rd_addr (exec_of_match_addr),
    .rd_data (rd_data)
  );

`ifdef NETWALK_AF_WRITE_FORWARD_EN
  logic                          fwd_sel;
  logic                          fwd_q;
  logic [PROGRAM_DATA_WIDTH-1:0] fwd_data_q;

  // NOTE: every variable gets a default at the top of always_comb so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    lookup_hit = exec_of_match_found & valid[exec_of_match_addr];
    fwd_sel    = 1'b0;
    if (exec_of_match_found && exec_of_match_addr == exec_program_addr) begin
      if (exec_delete_enable) begin
        lookup_hit = 1'b0;
      end else if (exec_program_enable) begin
        lookup_hit = 1'b1;
        fwd_sel    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) fwd_q <= 1'b0;
    else       fwd_q <= fwd_sel;
    if (fwd_sel) fwd_data_q <= exec_program_data;
  end

  assign fetched = fwd_q ? fwd_data_q : rd_data;
`else
  always_comb begin
    lookup_hit = exec_of_match_found & valid[exec_of_match_addr];
  end

  assign fetched = rd_data;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; this is what makes lookups read-before-write.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid    <= '0;
      enable_q <= 1'b0;
      header_q <= '0;
    end else begin
      if (exec_delete_enable)       valid[exec_program_addr] <= 1'b0;
      else if (exec_program_enable) valid[exec_program_addr] <= 1'b1;
      enable_q <= lookup_hit;
      header_q <= pkt_header_in;
    end
  end

  assign exec_action_enable = enable_q;
  assign exec_action_flag   = enable_q ? fetched[PROGRAM_DATA_WIDTH-1 -: ACTION_FLAG_WIDTH] : '0;
  assign exec_action_set    = enable_q ? fetched[ACTION_SET_WIDTH-1:0] : '0;
  assign pkt_header_out     = header_q;

endmodule

// File: tb/tb_netwalk_execution_engine_action_fetch_unit.sv
// Self-checking bench for the action fetch unit; honours NETWALK_AF_WRITE_FORWARD_EN.
module tb_netwalk_execution_engine_action_fetch_unit;

  localparam int AFW = 16;
  localparam int ASW = 356;
  localparam int AW  = 6;
  localparam int HW  = 512;
  localparam int PDW = AFW + ASW;

  logic           clk = 1'b0;
  logic           reset;
  logic [PDW-1:0] exec_program_data;
  logic [AW-1:0]  exec_program_addr;
  logic           exec_program_enable;
  logic           exec_delete_enable;
  logic [HW-1:0]  pkt_header_in;
  logic [AW-1:0]  exec_of_match_addr;
  logic           exec_of_match_found;
  logic [AFW-1:0] exec_action_flag;
  logic [ASW-1:0] exec_action_set;
  logic           exec_action_enable;
  logic [HW-1:0]  pkt_header_out;

  always #5 clk = ~clk;

  netwalk_execution_engine_action_fetch_unit dut (
    .clk                 (clk),
    .reset               (reset),
    .exec_program_data   (exec_program_data),
    .exec_program_addr   (exec_program_addr),
    .exec_program_enable (exec_program_enable),
    .exec_delete_enable  (exec_delete_enable),
    .pkt_header_in       (pkt_header_in),
    .exec_of_match_addr  (exec_of_match_addr),
    .exec_of_match_found (exec_of_match_found),
    .exec_action_flag    (exec_action_flag),
    .exec_action_set     (exec_action_set),
    .exec_action_enable  (exec_action_enable),
    .pkt_header_out      (pkt_header_out)
  );

  typedef struct packed {
    logic           en;
    logic [AFW-1:0] flag;
    logic [ASW-1:0] set;
    logic [HW-1:0]  hdr;
  } exp_t;

  typedef struct packed {
    logic [AW-1:0]  addr;
    logic [AFW-1:0] flag;
    logic [ASW-1:0] set;
  } vec_t;

  exp_t  sb_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  task automatic check(input string nm, input logic [HW-1:0] act, input logic [HW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue its expected result, compare after the edge.
  task automatic cyc(input logic rst, input logic pe, input logic de, input logic [AW-1:0] pa,
                     input logic [AFW-1:0] pf, input logic [ASW-1:0] ps,
                     input logic mf, input logic [AW-1:0] ma,
                     input logic ee, input logic [AFW-1:0] ef, input logic [ASW-1:0] es,
                     input string nm);
    exp_t          e;
    logic [HW-1:0] h;
    string         n;
    for (int w = 0; w < HW / 32; w++) h[w*32 +: 32] = $urandom();
    reset               = rst;
    exec_program_enable = pe;
    exec_delete_enable  = de;
    exec_program_addr   = pa;
    exec_program_data   = {pf, ps};
    exec_of_match_found = mf;
    exec_of_match_addr  = ma;
    pkt_header_in       = h;
    e.en   = ee;
    e.flag = ef;
    e.set  = es;
    e.hdr  = rst ? '0 : h;
    sb_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    n = name_q.pop_front();
    check({n, "_en"},   HW'(exec_action_enable), HW'(e.en));
    check({n, "_flag"}, HW'(exec_action_flag),   HW'(e.flag));
    check({n, "_set"},  HW'(exec_action_set),    HW'(e.set));
    check({n, "_hdr"},  pkt_header_out,          e.hdr);
  endtask

  task automatic look(input logic mf, input logic [AW-1:0] ma, input logic ee,
                      input logic [AFW-1:0] ef, input logic [ASW-1:0] es, input string nm);
    cyc(1'b0, 1'b0, 1'b0, '0, '0, '0, mf, ma, ee, ef, es, nm);
  endtask

  task automatic prog(input logic [AW-1:0] pa, input logic [AFW-1:0] pf,
                      input logic [ASW-1:0] ps, input string nm);
    cyc(1'b0, 1'b1, 1'b0, pa, pf, ps, 1'b0, '0, 1'b0, '0, '0, nm);
  endtask

  initial begin
    vec_t           tbl [16];
    logic [AFW-1:0] xf = 16'hABCD;
    logic [ASW-1:0] xs = 356'hDEAD_BEEF_0123_4567;
    logic [AFW-1:0] yf = 16'h1234;
    logic [ASW-1:0] ys = 356'h5555_AAAA_F00D;

    for (int k = 0; k < 16; k++)
      tbl[k] = '{addr: AW'(k / 4), flag: AFW'(k / 4), set: ASW'(k / 4 + 1)};

    // Reset with program and lookup requests that must be ignored.
    cyc(1'b1, 1'b1, 1'b0, 6'd7, 16'h7777, 356'h7, 1'b1, 6'd7, 1'b0, '0, '0, "rst0");
    cyc(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b1, 6'd0, 1'b0, '0, '0, "rst1");

    look(1'b1, 6'd0, 1'b0, '0, '0, "empty0");

    for (int i = 0; i < 5; i++) prog(AW'(i), AFW'(i), ASW'(i + 1), "prog");

    // Held match_found, address changes every 4 cycles: no bubbles.
    for (int k = 0; k < 16; k++) look(1'b1, tbl[k].addr, 1'b1, tbl[k].flag, tbl[k].set, "stream");

    cyc(1'b0, 1'b0, 1'b1, 6'd2, '0, '0, 1'b0, '0, 1'b0, '0, '0, "del2");
    look(1'b1, 6'd2, 1'b0, '0, '0, "look_del2");
    look(1'b1, 6'd3, 1'b1, 16'd3, 356'd4, "look3");

    // Program and delete together: delete wins.
    cyc(1'b0, 1'b1, 1'b1, 6'd6, xf, xs, 1'b0, '0, 1'b0, '0, '0, "prog_del6");
    look(1'b1, 6'd6, 1'b0, '0, '0, "look6");

    // Same-cycle program and lookup of a previously invalid entry.
`ifdef NETWALK_AF_WRITE_FORWARD_EN
    cyc(1'b0, 1'b1, 1'b0, 6'd5, xf, xs, 1'b1, 6'd5, 1'b1, xf, xs, "rbw5");
`else
    cyc(1'b0, 1'b1, 1'b0, 6'd5, xf, xs, 1'b1, 6'd5, 1'b0, '0, '0, "rbw5");
`endif
    look(1'b1, 6'd5, 1'b1, xf, xs, "look5");

    // Overwrite a valid entry while looking it up.
`ifdef NETWALK_AF_WRITE_FORWARD_EN
    cyc(1'b0, 1'b1, 1'b0, 6'd3, yf, ys, 1'b1, 6'd3, 1'b1, yf, ys, "rbw3");
`else
    cyc(1'b0, 1'b1, 1'b0, 6'd3, yf, ys, 1'b1, 6'd3, 1'b1, 16'd3, 356'd4, "rbw3");
`endif
    look(1'b1, 6'd3, 1'b1, yf, ys, "look3_new");

    // Delete a valid entry while looking it up.
`ifdef NETWALK_AF_WRITE_FORWARD_EN
    cyc(1'b0, 1'b0, 1'b1, 6'd4, '0, '0, 1'b1, 6'd4, 1'b0, '0, '0, "rbd4");
`else
    cyc(1'b0, 1'b0, 1'b1, 6'd4, '0, '0, 1'b1, 6'd4, 1'b1, 16'd4, 356'd5, "rbd4");
`endif
    look(1'b1, 6'd4, 1'b0, '0, '0, "look4_del");

    look(1'b0, 6'd0, 1'b0, '0, '0, "nomatch0");
    look(1'b1, 6'd7, 1'b0, '0, '0, "look7_rst_prog");
    look(1'b1, 6'd1, 1'b1, 16'd1, 356'd2, "look1");

    // Reset mid-stream with a live lookup, then every entry must be invalid.
    cyc(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b1, 6'd0, 1'b0, '0, '0, "rst_mid");
    look(1'b1, 6'd0, 1'b0, '0, '0, "post_rst0");
    look(1'b1, 6'd1, 1'b0, '0, '0, "post_rst1");
    look(1'b1, 6'd3, 1'b0, '0, '0, "post_rst3");
    look(1'b1, 6'd5, 1'b0, '0, '0, "post_rst5");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
